// File: rtl/instr_register_pkg.sv
`default_nettype none
// ============================================================================
// Package  : instr_register_pkg
// Brief    : Shared types for instr_register and its read-side exec unit.
// Revision : 1.0 - initial release
// ============================================================================
package instr_register_pkg;

    localparam int c_OPERAND_W = 32;
    localparam int c_RES_W     = 64;
    localparam int c_ADDR_W    = 5;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [c_OPERAND_W-1:0] operand_t;
    typedef logic        [c_ADDR_W-1:0]    address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [c_RES_W-1:0] result_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } exec_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_alu.sv
`default_nettype none
// ============================================================================
// Module   : instr_alu
// Brief    : Combinational signed ALU for one captured instruction word.
// Revision : 1.0 - initial release
// ============================================================================
module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t i_instr,
    output result_t      o_result,
    output logic         o_err
);

    result_t w_a;
    result_t w_b;

    always_comb begin
        w_a      = {{(c_RES_W-c_OPERAND_W){i_instr.op_a[c_OPERAND_W-1]}}, i_instr.op_a};
        w_b      = {{(c_RES_W-c_OPERAND_W){i_instr.op_b[c_OPERAND_W-1]}}, i_instr.op_b};
        o_result = '0;
        o_err    = 1'b0;
        case (i_instr.opc)
            ZERO:  o_result = '0;
            PASSA: o_result = w_a;
            PASSB: o_result = w_b;
            ADD:   o_result = w_a + w_b;
            SUB:   o_result = w_a - w_b;
            MULT:  o_result = w_a * w_b;
            DIV: begin
                if (w_b == '0) o_err    = 1'b1;
                else           o_result = w_a / w_b;
            end
            MOD: begin
                if (w_b == '0) o_err    = 1'b1;
                else           o_result = w_a % w_b;
            end
            // Encodings outside opcode_t arrive here as raw bits.
            default: o_err = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_exec_unit
// Brief    : Walks a block of instr_register entries, executes each one and
//            streams results out under a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int RES_W  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       first_addr,
    input  logic [ADDR_W:0]         count,
    output logic [ADDR_W-1:0]       read_pointer,
    input  instruction_t            instruction_word,
    output logic signed [RES_W-1:0] result,
    output logic [ADDR_W-1:0]       result_addr,
    output logic                    result_err,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    busy,
    output logic                    done
);

    exec_state_t  r_state;
    logic [ADDR_W:0] r_remaining;
    instruction_t r_instr;
    result_t      w_alu_result;
    logic         w_alu_err;

    instr_alu u_alu (
        .i_instr  (r_instr),
        .o_result (w_alu_result),
        .o_err    (w_alu_err)
    );

    // read_pointer doubles as the block pointer; it only moves when heading
    // back into FETCH so it stays put through EXEC/HOLD/DONE/IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_remaining  <= '0;
            r_instr      <= '0;
            read_pointer <= '0;
            result       <= '0;
            result_addr  <= '0;
            result_err   <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && (count != '0)) begin
                        read_pointer <= first_addr;
                        r_remaining  <= count;
                        busy         <= 1'b1;
                        r_state      <= FETCH;
                    end
                end
                FETCH: begin
                    r_instr <= instruction_word;
                    r_state <= EXEC;
                end
                EXEC: begin
                    result       <= w_alu_result;
                    result_err   <= w_alu_err;
                    result_addr  <= read_pointer;
                    result_valid <= 1'b1;
                    r_state      <= HOLD;
                end
                HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        r_remaining  <= r_remaining - (ADDR_W+1)'(1);
                        if (r_remaining == (ADDR_W+1)'(1)) begin
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            read_pointer <= read_pointer + ADDR_W'(1);
                            r_state      <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_exec_unit
// Brief    : Self-checking bench; models instr_register as a TB array and
//            scores results against a queue of expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    localparam int ADDR_W = 5;
    localparam int RES_W  = 64;

    typedef struct packed {
        logic signed [RES_W-1:0] res;
        logic [ADDR_W-1:0]       addr;
        logic                    err;
    } exp_t;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic [ADDR_W-1:0]       first_addr;
    logic [ADDR_W:0]         count;
    logic [ADDR_W-1:0]       read_pointer;
    instruction_t            instruction_word;
    logic signed [RES_W-1:0] result;
    logic [ADDR_W-1:0]       result_addr;
    logic                    result_err;
    logic                    result_valid;
    logic                    result_ready;
    logic                    busy;
    logic                    done;

    instruction_t mem [32];
    exp_t         sb[$];
    int           n_checks;
    int           n_fail;

    assign instruction_word = mem[read_pointer];

    instr_exec_unit #(.ADDR_W(ADDR_W), .RES_W(RES_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .result           (result),
        .result_addr      (result_addr),
        .result_err       (result_err),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instruction_t mk(input logic [3:0] opc, input logic signed [31:0] a,
                                        input logic signed [31:0] b);
        return instruction_t'({opc, a, b});
    endfunction

    task automatic pulse_start(input logic [ADDR_W-1:0] fa, input logic [ADDR_W:0] cnt);
        @(negedge clk);
        start = 1'b1; first_addr = fa; count = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({result, result_addr, result_err, result_valid, busy, done, read_pointer} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b busy=%0b done=%0b ptr=%0d result=%0d, all required 0",
                     result_valid, busy, done, read_pointer, result);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({result_valid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release: valid=%0b busy=%0b done=%0b, required 0", result_valid, busy, done);
        end
    endtask

    task automatic test_single_add();
        exp_t e;
        mem[0] = mk(ADD, 5, -7);
        result_ready = 1'b1;
        sb.push_back('{-64'sd2, 5'd0, 1'b0});
        pulse_start(5'd0, 6'd1);
        n_checks++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_fetch: busy=%0b valid=%0b, required busy=1 valid=0", busy, result_valid);
        end
        @(negedge clk);
        n_checks++;
        if (result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_not_early: valid=%0b, required 0", result_valid);
        end
        @(negedge clk);
        n_checks++;
        if (result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL add_latency: valid=%0b, required 1", result_valid);
        end
        e = sb.pop_front();
        n_checks++;
        if (result !== e.res || result_addr !== e.addr || result_err !== e.err) begin
            n_fail++;
            $display("FAIL add_result: got %0d@%0d err=%0b, required %0d@%0d err=%0b",
                     result, result_addr, result_err, e.res, e.addr, e.err);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done: done=%0b valid=%0b, required done=1 valid=0", done, result_valid);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL add_idle: done=%0b busy=%0b, required 0", done, busy);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        mem[30] = mk(MULT, -65536, 65536);
        mem[31] = mk(SUB, 3, 10);
        mem[0]  = mk(DIV, -7, 2);
        result_ready = 1'b1;
        sb.push_back('{-64'sd4294967296, 5'd30, 1'b0});
        sb.push_back('{-64'sd7, 5'd31, 1'b0});
        sb.push_back('{-64'sd3, 5'd0, 1'b0});
        pulse_start(5'd30, 6'd3);
        for (int i = 0; i < 3; i++) begin
            int t;
            t = 0;
            while (!result_valid && t < 20) begin @(negedge clk); t++; end
            n_checks++;
            if (!result_valid) begin
                n_fail++;
                $display("FAIL wrap_timeout: valid=0 after %0d cycles, required 1", t);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || result_addr !== e.addr || result_err !== e.err) begin
                    n_fail++;
                    $display("FAIL wrap_result: got %0d@%0d err=%0b, required %0d@%0d err=%0b",
                             result, result_addr, result_err, e.res, e.addr, e.err);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_done: done=%0b, required 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_alu_ops();
        exp_t e;
        mem[10] = mk(DIV, 9, 0);
        mem[11] = mk(MOD, 9, 0);
        mem[12] = mk(4'hF, 1, 2);
        mem[13] = mk(MOD, -7, 2);
        mem[14] = mk(PASSA, -123, 456);
        mem[15] = mk(PASSB, -123, 456);
        mem[16] = mk(ZERO, 77, 88);
        mem[17] = mk(DIV, 32'sh8000_0000, -1);
        sb.push_back('{64'sd0, 5'd10, 1'b1});
        sb.push_back('{64'sd0, 5'd11, 1'b1});
        sb.push_back('{64'sd0, 5'd12, 1'b1});
        sb.push_back('{-64'sd1, 5'd13, 1'b0});
        sb.push_back('{-64'sd123, 5'd14, 1'b0});
        sb.push_back('{64'sd456, 5'd15, 1'b0});
        sb.push_back('{64'sd0, 5'd16, 1'b0});
        sb.push_back('{64'sd2147483648, 5'd17, 1'b0});
        result_ready = 1'b1;
        pulse_start(5'd10, 6'd8);
        for (int i = 0; i < 8; i++) begin
            int t;
            t = 0;
            while (!result_valid && t < 20) begin @(negedge clk); t++; end
            n_checks++;
            if (!result_valid) begin
                n_fail++;
                $display("FAIL alu_timeout: item %0d valid=0, required 1", i);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || result_addr !== e.addr || result_err !== e.err) begin
                    n_fail++;
                    $display("FAIL alu_result: got %0d@%0d err=%0b, required %0d@%0d err=%0b",
                             result, result_addr, result_err, e.res, e.addr, e.err);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_done: done=%0b, required 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        exp_t e;
        int   t;
        mem[5] = mk(SUB, 100, 1);
        sb.push_back('{64'sd99, 5'd5, 1'b0});
        result_ready = 1'b0;
        pulse_start(5'd5, 6'd1);
        t = 0;
        while (!result_valid && t < 20) begin @(negedge clk); t++; end
        e = sb.pop_front();
        n_checks++;
        if (result_valid !== 1'b1 || result !== e.res || result_addr !== e.addr || result_err !== e.err) begin
            n_fail++;
            $display("FAIL stall_first: valid=%0b got %0d@%0d, required %0d@%0d",
                     result_valid, result, result_addr, e.res, e.addr);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (result_valid !== 1'b1 || result !== e.res || result_addr !== e.addr ||
                result_err !== e.err || read_pointer !== 5'd5 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d valid=%0b got %0d@%0d ptr=%0d done=%0b, required %0d@5 ptr=5",
                         i, result_valid, result, result_addr, read_pointer, done, e.res);
            end
        end
        result_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (result_valid !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: valid=%0b done=%0b, required valid=0 done=1", result_valid, done);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        exp_t e;
        logic bad;
        result_ready = 1'b1;
        pulse_start(5'd3, 6'd0);
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL count_zero: busy/done/valid went high, required all 0");
        end
        mem[20] = mk(ADD, 1, 2);
        mem[21] = mk(ADD, 10, 20);
        sb.push_back('{64'sd3, 5'd20, 1'b0});
        sb.push_back('{64'sd30, 5'd21, 1'b0});
        pulse_start(5'd20, 6'd2);
        start = 1'b1; first_addr = 5'd0; count = 6'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            int t;
            t = 0;
            while (!result_valid && t < 20) begin @(negedge clk); t++; end
            n_checks++;
            if (!result_valid) begin
                n_fail++;
                $display("FAIL busy_start_timeout: item %0d valid=0, required 1", i);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || result_addr !== e.addr || result_err !== e.err) begin
                    n_fail++;
                    $display("FAIL busy_start_result: got %0d@%0d, required %0d@%0d",
                             result, result_addr, e.res, e.addr);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_done: done=%0b, required 1", done);
        end
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy !== 1'b0 || result_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL busy_start_extra: activity after block end, required idle");
        end
    endtask

    task automatic test_reset_mid_block();
        exp_t e;
        logic bad;
        int   t;
        mem[24] = mk(PASSA, 11, 0);
        mem[25] = mk(ADD, -1, -1);
        mem[26] = mk(MULT, -3, 7);
        mem[27] = mk(SUB, 0, 5);
        sb.push_back('{64'sd11, 5'd24, 1'b0});
        sb.push_back('{-64'sd2, 5'd25, 1'b0});
        result_ready = 1'b0;
        pulse_start(5'd24, 6'd4);
        for (int i = 0; i < 2; i++) begin
            t = 0;
            while (!result_valid && t < 20) begin @(negedge clk); t++; end
            e = sb.pop_front();
            n_checks++;
            if (result_valid !== 1'b1 || result !== e.res || result_addr !== e.addr) begin
                n_fail++;
                $display("FAIL rst_mid_pre: valid=%0b got %0d@%0d, required %0d@%0d",
                         result_valid, result, result_addr, e.res, e.addr);
            end
            if (i == 0) begin
                result_ready = 1'b1;
                @(negedge clk);
                result_ready = 1'b0;
            end
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({result, result_addr, result_err, result_valid, busy, done, read_pointer} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async: valid=%0b busy=%0b ptr=%0d result=%0d, all required 0",
                     result_valid, busy, read_pointer, result);
        end
        @(negedge clk);
        reset = 1'b0;
        result_ready = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: activity after reset, required idle");
        end
        sb.push_back('{-64'sd21, 5'd26, 1'b0});
        pulse_start(5'd26, 6'd1);
        t = 0;
        while (!result_valid && t < 20) begin @(negedge clk); t++; end
        e = sb.pop_front();
        n_checks++;
        if (result_valid !== 1'b1 || result !== e.res || result_addr !== e.addr || result_err !== e.err) begin
            n_fail++;
            $display("FAIL rst_mid_restart: valid=%0b got %0d@%0d, required %0d@%0d",
                     result_valid, result, result_addr, e.res, e.addr);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_restart_done: done=%0b, required 1", done);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        start = 1'b0;
        first_addr = '0;
        count = '0;
        result_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        test_reset();
        test_single_add();
        test_wrap();
        test_alu_ops();
        test_stall();
        test_start_ignored();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
